// File: rtl/des_decrypt_key_sched_if.sv
// Handshake/bus bundle for the DES key schedule.
// The requester side (master) loads a PC1-permuted key and consumes
// subkeys; the schedule itself sits on the slave side.
// Optional macro DES_KEY_SCHED_ENC_MODE_EN adds the encrypt select line.
interface des_decrypt_key_sched_if;
  logic        start;
  logic [55:0] pc1_key;
`ifdef DES_KEY_SCHED_ENC_MODE_EN
  logic        encrypt;
`endif
  logic [47:0] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [3:0]  round;
  logic        busy;
  logic        done;

`ifdef DES_KEY_SCHED_ENC_MODE_EN
  modport master (
    output start, pc1_key, encrypt, subkey_ready,
    input  subkey, subkey_valid, round, busy, done
  );
  modport slave (
    input  start, pc1_key, encrypt, subkey_ready,
    output subkey, subkey_valid, round, busy, done
  );
`else
  modport master (
    output start, pc1_key, subkey_ready,
    input  subkey, subkey_valid, round, busy, done
  );
  modport slave (
    input  start, pc1_key, subkey_ready,
    output subkey, subkey_valid, round, busy, done
  );
`endif
endinterface

// File: rtl/des_decrypt_key_sched.sv
// DES round-key generator, decrypt order (K16 first, K1 last).
//
// A PC1-permuted key {C0,D0} is loaded into the CD register on start.
// Because the 16 encryption rotations add up to a full 28-bit turn,
// PC2(C0,D0) is already K16; each accepted subkey then rotates both
// halves right by the shift that produced the previous encryption key.
// The subkey output is a purely combinational PC2 of the CD register.
//
// Optional macro DES_KEY_SCHED_ENC_MODE_EN adds an encrypt input, sampled
// with start, that switches to K1..K16 order (left rotations, with the
// first rotation applied at load time). Without the macro the block is
// decrypt-only and the encrypt line does not exist.
module des_decrypt_key_sched #(
  parameter int NROUNDS = 16  // only 16 is meaningful for DES
) (
  input logic                    clk,
  input logic                    rst,
  des_decrypt_key_sched_if.slave bus
);

  localparam logic [3:0] LAST_ROUND = 4'(NROUNDS - 1);

  // PC2 selection table (FIPS 46-3), 1-based source bit of the 56-bit CD
  // value (bit 1 = MSB), listed from output bit 1 (MSB) to output bit 48.
  localparam logic [287:0] PC2_TBL = {
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  // PC2 compression: walk the table MSB-first and shift the selected
  // CD bits into the result.
  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [287:0] tbl;
    logic [47:0]  res;
    logic [5:0]   src;
    logic [5:0]   idx;
    tbl = PC2_TBL;
    res = 48'd0;
    for (int i = 0; i < 48; i++) begin
      src = tbl[287:282];
      idx = 6'd56 - src;
      res = {res[46:0], cd[idx]};
      tbl = tbl << 6'd6;
    end
    return res;
  endfunction

  // The step taken after delivering subkey number r is a single-bit
  // rotation for r = 0, 7, 14 and a double rotation otherwise. This holds
  // for both directions: decrypt uses S[16-r], encrypt uses S[r+2], and
  // S is 1 at positions 1, 2, 9 and 16.
  function automatic logic shift_by_two(input logic [3:0] r);
    return !((r == 4'd0) || (r == 4'd7) || (r == 4'd14));
  endfunction

  // Rotate C and D right independently (no carry between the halves).
  function automatic logic [55:0] rot_right(input logic [55:0] cd,
                                            input logic        two);
    logic [27:0] c;
    logic [27:0] d;
    c = cd[55:28];
    d = cd[27:0];
    if (two) begin
      return {c[1:0], c[27:2], d[1:0], d[27:2]};
    end else begin
      return {c[0], c[27:1], d[0], d[27:1]};
    end
  endfunction

`ifdef DES_KEY_SCHED_ENC_MODE_EN
  // Rotate C and D left independently (no carry between the halves).
  function automatic logic [55:0] rot_left(input logic [55:0] cd,
                                           input logic        two);
    logic [27:0] c;
    logic [27:0] d;
    c = cd[55:28];
    d = cd[27:0];
    if (two) begin
      return {c[25:0], c[27:26], d[25:0], d[27:26]};
    end else begin
      return {c[26:0], c[27], d[26:0], d[27]};
    end
  endfunction
`endif

  state_t      state_r;
  state_t      state_s;
  logic [55:0] cd_r;
  logic [55:0] cd_s;
  logic [3:0]  round_r;
  logic [3:0]  round_s;
  logic        valid_r;
  logic        valid_s;
  logic        done_r;
  logic        done_s;
  logic        busy_r;
  logic        busy_s;
  logic        handshake_s;
`ifdef DES_KEY_SCHED_ENC_MODE_EN
  logic        enc_r;
  logic        enc_s;
`endif

  assign handshake_s = valid_r & bus.subkey_ready;

  // Next-state, key-register update and status flag decode.
  always_comb begin
    state_s = state_r;
    cd_s    = cd_r;
    round_s = round_r;
`ifdef DES_KEY_SCHED_ENC_MODE_EN
    enc_s   = enc_r;
`endif
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          round_s = 4'd0;
          state_s = ROUND;
`ifdef DES_KEY_SCHED_ENC_MODE_EN
          enc_s = bus.encrypt;
          if (bus.encrypt) begin
            // K1 is PC2 of the key after the first (single) left shift.
            cd_s = rot_left(bus.pc1_key, 1'b0);
          end else begin
            cd_s = bus.pc1_key;
          end
`else
          cd_s = bus.pc1_key;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      ROUND: begin
        if (handshake_s) begin
          if (round_r == LAST_ROUND) begin
            // Last subkey taken: CD is left as is until the next load.
            state_s = DONE;
          end else begin
            round_s = round_r + 4'd1;
`ifdef DES_KEY_SCHED_ENC_MODE_EN
            if (enc_r) begin
              cd_s = rot_left(cd_r, shift_by_two(round_r));
            end else begin
              cd_s = rot_right(cd_r, shift_by_two(round_r));
            end
`else
            cd_s = rot_right(cd_r, shift_by_two(round_r));
`endif
          end
        end else begin
          // Stalled: subkey, round and CD hold.
          state_s = ROUND;
        end
      end
      DONE: begin
        // start is deliberately not looked at here.
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    valid_s = (state_s == ROUND);
    done_s  = (state_s == DONE);
    busy_s  = (state_s != IDLE);
  end

  // State, CD register, round counter and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cd_r    <= 56'd0;
      round_r <= 4'd0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
`ifdef DES_KEY_SCHED_ENC_MODE_EN
      enc_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      cd_r    <= cd_s;
      round_r <= round_s;
      valid_r <= valid_s;
      done_r  <= done_s;
      busy_r  <= busy_s;
`ifdef DES_KEY_SCHED_ENC_MODE_EN
      enc_r   <= enc_s;
`endif
    end
  end

  // Subkey is combinational from the CD register: no added latency.
  assign bus.subkey       = pc2(cd_r);
  assign bus.subkey_valid = valid_r;
  assign bus.round        = round_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;

endmodule
